vx_tcu_fedp_ctrl: RTL

Issue controller for one TCU fused dot-product (FEDP) pipeline. It accepts dot-product step requests tagged with an accumulation slot, and drives the FEDP operands, format and `enable`. It tracks in-flight steps and chains partial sums of multi-step K-reductions back as the next step's C input. Slots are interleaved so independent accumulations hide pipeline latency. It sits between the TCU operand-gather logic and the FEDP instance, and returns final sums on a valid/ready response port.

---
 rtl/vx_tcu_pkg.sv | 24 ++
 rtl/vx_tcu_fedp_ctrl_track.sv | 36 +++
 rtl/vx_tcu_fedp_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/vx_tcu_pkg.sv
// Shared TCU definitions: source format codes and the FEDP issue-tracker entry.
package vx_tcu_pkg;

    localparam int XLEN = 32;

    // Tracker slot field is sized for the largest supported slot count (64);
    // instances use the low log2(NUM_SLOTS) bits and keep the rest zero.
    localparam int TCU_SLOT_BITS = 6;

    localparam logic [2:0] TCU_FMT_FP16 = 3'd1;
    localparam logic [2:0] TCU_FMT_BF16 = 3'd2;
    localparam logic [2:0] TCU_FMT_TF32 = 3'd3;

    typedef struct packed {
        logic                     valid;
        logic [TCU_SLOT_BITS-1:0] slot;
        logic                     last;
    } tcu_trk_t;

    function automatic logic tcu_fmt_legal(input logic [2:0] fmt);
        return fmt inside {TCU_FMT_FP16, TCU_FMT_BF16, TCU_FMT_TF32};
    endfunction

endpackage

// File: rtl/vx_tcu_fedp_ctrl_track.sv
// In-flight step tracker: LATENCY-deep shift of {valid, slot, last} that only
// advances with the FEDP enable, so the tail lines up with fedp_d_val.
module vx_tcu_fedp_ctrl_track
    import vx_tcu_pkg::*;
#(
    parameter int LATENCY   = 16,
    parameter int NUM_SLOTS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  tcu_trk_t             in_ent,
    output tcu_trk_t             tail,
    output logic [NUM_SLOTS-1:0] retire
);

    tcu_trk_t [LATENCY-1:0] stage;

    // Shift entries toward the tail on enabled cycles; reset empties the pipe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stage <= '0;
        end else if (enable) begin
            stage[0] <= in_ent;
            for (int i = 1; i < LATENCY; i++)
                stage[i] <= stage[i-1];
        end
    end

    assign tail = stage[LATENCY-1];

    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_ret
        assign retire[s] = tail.valid & (tail.slot == TCU_SLOT_BITS'(s));
    end

endmodule

// File: rtl/vx_tcu_fedp_ctrl.sv
// FEDP issue controller: issues dot-product steps, chains partial sums per
// accumulation slot and returns final sums on a valid/ready response port.
// Optional: VX_TCU_FEDP_CTRL_BYPASS_EN forwards a retiring partial sum straight
// into a dependent step issued in the same cycle (turnaround LATENCY instead of
// LATENCY+1).
module vx_tcu_fedp_ctrl
    import vx_tcu_pkg::*;
#(
    parameter int N         = 4,
    parameter int LATENCY   = 16,
    parameter int NUM_SLOTS = 4,
    localparam int SLOT_W   = $clog2(NUM_SLOTS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [SLOT_W-1:0]         req_slot,
    input  logic                      req_first,
    input  logic                      req_last,
    input  logic [2:0]                req_fmt_s,
    input  logic [N-1:0][XLEN-1:0]    req_a_row,
    input  logic [N-1:0][XLEN-1:0]    req_b_col,
    input  logic [XLEN-1:0]           req_c_val,
    output logic                      fedp_enable,
    output logic [2:0]                fedp_fmt_s,
    output logic [N-1:0][XLEN-1:0]    fedp_a_row,
    output logic [N-1:0][XLEN-1:0]    fedp_b_col,
    output logic [XLEN-1:0]           fedp_c_val,
    input  logic [XLEN-1:0]           fedp_d_val,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [SLOT_W-1:0]         rsp_slot,
    output logic [XLEN-1:0]           rsp_d_val
);

    tcu_trk_t             tail, issue_ent;
    logic [NUM_SLOTS-1:0] retire, busy, busy_set, busy_clr;
    logic [XLEN-1:0]      acc [NUM_SLOTS];
    logic                 rsp_vld_q;
    logic [SLOT_W-1:0]    rsp_slot_q;
    logic [XLEN-1:0]      rsp_d_q;
    logic                 stall, accept, byp_hit, last_go;

    // Response outputs read as idle while reset is asserted.
    assign rsp_valid = reset & rsp_vld_q;
    assign rsp_slot  = reset ? rsp_slot_q : '0;
    assign rsp_d_val = reset ? rsp_d_q    : '0;

    // Only a final result that cannot be handed off freezes the pipeline.
    assign stall       = rsp_valid & ~rsp_ready & tail.valid & tail.last;
    assign fedp_enable = ~stall;
    assign last_go     = tail.valid & tail.last & ~stall;

`ifdef VX_TCU_FEDP_CTRL_BYPASS_EN
    assign byp_hit = ~req_first & tail.valid & ~tail.last
                   & (tail.slot == TCU_SLOT_BITS'(req_slot));
`else
    assign byp_hit = 1'b0;
`endif

    assign req_ready = reset & ~stall & (~busy[req_slot] | byp_hit);
    assign accept    = req_valid & req_ready;

    assign fedp_fmt_s = req_fmt_s;
    assign fedp_a_row = req_a_row;
    assign fedp_b_col = req_b_col;
    assign fedp_c_val = req_first ? req_c_val : (byp_hit ? fedp_d_val : acc[req_slot]);

    // Build the tracker entry for this cycle; idle cycles enter as invalid.
    always_comb begin
        issue_ent       = '0;
        issue_ent.valid = accept;
        issue_ent.slot  = TCU_SLOT_BITS'(req_slot);
        issue_ent.last  = req_last;
    end

    vx_tcu_fedp_ctrl_track #(
        .LATENCY   (LATENCY),
        .NUM_SLOTS (NUM_SLOTS)
    ) u_track (
        .clk    (clk),
        .reset  (reset),
        .enable (fedp_enable),
        .in_ent (issue_ent),
        .tail   (tail),
        .retire (retire)
    );

    // A stalled last tail has not retired yet, so its slot stays busy.
    assign busy_clr = retire & {NUM_SLOTS{~tail.last | ~stall}};
    assign busy_set = NUM_SLOTS'(accept) << req_slot;

    // Slot busy: set wins over clear so a bypassed re-issue keeps the slot held.
    always_ff @(posedge clk) begin
        if (!reset) busy <= '0;
        else        busy <= (busy & ~busy_clr) | busy_set;
    end

    // Partial sums land in the slot accumulator; not reset by design.
    always_ff @(posedge clk) begin
        for (int s = 0; s < NUM_SLOTS; s++)
            if (reset && retire[s] && !tail.last)
                acc[s] <= fedp_d_val;
    end

    // Response register: a new load beats the handshake that empties it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rsp_vld_q  <= 1'b0;
            rsp_slot_q <= '0;
            rsp_d_q    <= '0;
        end else if (last_go) begin
            rsp_vld_q  <= 1'b1;
            rsp_slot_q <= SLOT_W'(tail.slot);
            rsp_d_q    <= fedp_d_val;
        end else if (rsp_valid && rsp_ready) begin
            rsp_vld_q  <= 1'b0;
        end
    end

    a_fmt_legal: assert property (@(posedge clk) disable iff (!reset)
        accept |-> tcu_fmt_legal(req_fmt_s));

endmodule
